// File: rtl/d5m_pkg.sv
// Shared definitions for the D5M capture sequencer: CSR map, register bit
// positions and the sequencer state encoding.
package d5m_pkg;

  localparam logic [2:0] ADDR_CTRL        = 3'd0;
  localparam logic [2:0] ADDR_STATUS      = 3'd1;
  localparam logic [2:0] ADDR_FRAME_LIMIT = 3'd2;
  localparam logic [2:0] ADDR_FRAME_COUNT = 3'd3;
  localparam logic [2:0] ADDR_BUF0_BASE   = 3'd4;
  localparam logic [2:0] ADDR_BUF1_BASE   = 3'd5;
  localparam logic [2:0] ADDR_LAST_PIXELS = 3'd6;

  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_MODE    = 1;
  localparam int unsigned CTRL_PATTERN = 2;
  localparam int unsigned CTRL_IRQ_EN  = 3;

  localparam int unsigned STAT_BUSY       = 0;
  localparam int unsigned STAT_FRAME_DONE = 1;
  localparam int unsigned STAT_OVERRUN    = 2;
  localparam int unsigned STAT_BUF_IDX    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/d5m_capture_ctrl_if.sv
// Avalon-MM CSR port of the capture sequencer; master = bus host side.
interface d5m_capture_ctrl_if;
  logic [2:0]  slave_address;
  logic        slave_chipselect;
  logic        slave_write;
  logic        slave_read;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;

  modport master (
    output slave_address, slave_chipselect, slave_write, slave_read, slave_writedata,
    input  slave_readdata
  );

  modport slave (
    input  slave_address, slave_chipselect, slave_write, slave_read, slave_writedata,
    output slave_readdata
  );
endinterface

// File: rtl/d5m_capture_csr.sv
// CSR file of the capture sequencer: control/limit/base registers, sticky
// W1C status, registered read mux, irq and active buffer base.
module d5m_capture_csr
  import d5m_pkg::*;
#(
  parameter int unsigned PXL_W  = 32,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  d5m_capture_ctrl_if.slave bus,
  input  logic              busy,
  input  logic              active_idx,
  input  logic              idx_next,
  input  logic              frame_done_set,
  input  logic              overrun_set,
  input  logic              run_hw_clr,
  input  logic [FCNT_W-1:0] frame_count,
  input  logic [PXL_W-1:0]  last_pixels,
  output logic              run,
  output logic              mode,
  output logic              pattern_enable,
  output logic [FCNT_W-1:0] frame_limit,
  output logic [31:0]       buffer_base,
  output logic              irq
);

  logic [3:0]        ctrl_q, ctrl_d;
  logic              done_q, done_d, ovr_q, ovr_d;
  logic [FCNT_W-1:0] limit_q, limit_d;
  logic [31:0]       buf0_q, buf0_d, buf1_q, buf1_d;
  logic [31:0]       rd_mux;
  logic              wr_en, rd_en;

  assign wr_en = bus.slave_chipselect & bus.slave_write;
  assign rd_en = bus.slave_chipselect & bus.slave_read;

  // Hardware set is applied after the software clear so a same-cycle set wins.
  always_comb begin
    ctrl_d  = ctrl_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    limit_d = limit_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (wr_en) begin
      case (bus.slave_address)
        ADDR_CTRL:        ctrl_d  = bus.slave_writedata[3:0];
        ADDR_STATUS: begin
          if (bus.slave_writedata[STAT_FRAME_DONE]) done_d = 1'b0;
          if (bus.slave_writedata[STAT_OVERRUN])    ovr_d  = 1'b0;
        end
        ADDR_FRAME_LIMIT: limit_d = bus.slave_writedata[FCNT_W-1:0];
        ADDR_BUF0_BASE:   buf0_d  = bus.slave_writedata;
        ADDR_BUF1_BASE:   buf1_d  = bus.slave_writedata;
        default: ;
      endcase
    end
    if (run_hw_clr)     ctrl_d[CTRL_RUN] = 1'b0;
    if (frame_done_set) done_d = 1'b1;
    if (overrun_set)    ovr_d  = 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.slave_address)
      ADDR_CTRL:        rd_mux[3:0] = ctrl_q;
      ADDR_STATUS:      rd_mux[3:0] = {active_idx, ovr_q, done_q, busy};
      ADDR_FRAME_LIMIT: rd_mux      = 32'(limit_q);
      ADDR_FRAME_COUNT: rd_mux      = 32'(frame_count);
      ADDR_BUF0_BASE:   rd_mux      = buf0_q;
      ADDR_BUF1_BASE:   rd_mux      = buf1_q;
      ADDR_LAST_PIXELS: rd_mux      = 32'(last_pixels);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q             <= '0;
      done_q             <= 1'b0;
      ovr_q              <= 1'b0;
      limit_q            <= '0;
      buf0_q             <= '0;
      buf1_q             <= '0;
      buffer_base        <= '0;
      irq                <= 1'b0;
      bus.slave_readdata <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      limit_q     <= limit_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      buffer_base <= idx_next ? buf1_d : buf0_d;
      irq         <= ctrl_d[CTRL_IRQ_EN] & (done_d | ovr_d);
      if (rd_en) bus.slave_readdata <= rd_mux;
    end
  end

  assign run            = ctrl_q[CTRL_RUN];
  assign mode           = ctrl_q[CTRL_MODE];
  assign pattern_enable = ctrl_q[CTRL_PATTERN];
  assign frame_limit    = limit_q;

endmodule

// File: rtl/d5m_capture_ctrl.sv
// D5M frame-capture sequencer: gates pixel frames to the writer, counts
// frames/pixels and ping-pongs the destination buffer.
module d5m_capture_ctrl
  import d5m_pkg::*;
#(
  parameter int unsigned PXL_W  = 32,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  d5m_capture_ctrl_if.slave bus,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              capture_gate,
  output logic              pattern_enable,
  output logic [31:0]       buffer_base,
  output logic              buffer_swap,
  output logic              irq
);

  state_t            state;
  logic [PXL_W-1:0]  pix_cnt, pix_inc, last_pixels;
  logic [FCNT_W-1:0] frame_count, count_inc, frame_limit, limit_eff;
  logic              idx, idx_next;
  logic              run, mode;
  logic              arm, frame_complete, resync, limit_hit, run_hw_clr;

  assign arm            = (state == ST_IDLE) & run;
  assign frame_complete = (state == ST_CAPTURE) & in_valid & in_eop;
  assign resync         = (state == ST_CAPTURE) & in_valid & in_sop & ~in_eop;
  assign pix_inc        = (&pix_cnt) ? pix_cnt : pix_cnt + 1'b1;
  assign count_inc      = frame_count + 1'b1;
  assign limit_eff      = (frame_limit == '0) ? FCNT_W'(1) : frame_limit;
  assign limit_hit      = mode & (count_inc >= limit_eff);
  assign run_hw_clr     = frame_complete & limit_hit;
  assign idx_next       = arm ? 1'b0 : (idx ^ frame_complete);
  assign capture_gate   = in_valid & (((state == ST_ARMED) & in_sop) | (state == ST_CAPTURE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pix_cnt     <= '0;
      last_pixels <= '0;
      frame_count <= '0;
      idx         <= 1'b0;
      buffer_swap <= 1'b0;
    end else begin
      buffer_swap <= 1'b0;
      case (state)
        ST_IDLE: if (run) begin
          state       <= ST_ARMED;
          frame_count <= '0;
          idx         <= 1'b0;
        end
        ST_ARMED: begin
          if (in_valid & in_sop) begin
            state   <= ST_CAPTURE;
            pix_cnt <= PXL_W'(1);
          end else if (!run) begin
            state <= ST_IDLE;
          end
        end
        ST_CAPTURE: if (in_valid) begin
          if (in_eop) begin
            frame_count <= count_inc;
            last_pixels <= pix_inc;
            idx         <= ~idx;
            buffer_swap <= 1'b1;
            state       <= (!run || limit_hit) ? ST_IDLE : ST_ARMED;
          end else if (in_sop) begin
            pix_cnt <= PXL_W'(1);
          end else begin
            pix_cnt <= pix_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  d5m_capture_csr #(
    .PXL_W (PXL_W),
    .FCNT_W(FCNT_W)
  ) u_csr (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .busy          (state != ST_IDLE),
    .active_idx    (idx),
    .idx_next      (idx_next),
    .frame_done_set(frame_complete),
    .overrun_set   (resync),
    .run_hw_clr    (run_hw_clr),
    .frame_count   (frame_count),
    .last_pixels   (last_pixels),
    .run           (run),
    .mode          (mode),
    .pattern_enable(pattern_enable),
    .frame_limit   (frame_limit),
    .buffer_base   (buffer_base),
    .irq           (irq)
  );

endmodule

// File: tb/tb_d5m_capture_ctrl.sv
// Self-checking bench for d5m_capture_ctrl: randomized beat spacing and buffer
// addresses against a frame-level reference model.
module tb_d5m_capture_ctrl;
  import d5m_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic        capture_gate, pattern_enable, buffer_swap, irq;
  logic [31:0] buffer_base;

  int n_checks = 0;
  int n_errors = 0;
  int swap_seen = 0;

  // Frame-level reference model
  logic        m_run = 1'b0, m_mode = 1'b0, m_idx = 1'b0;
  int          m_limit = 0, m_count = 0, m_last = 0;
  logic [31:0] buf0 = '0, buf1 = '0;

  always #5 clk = ~clk;

  d5m_capture_ctrl_if bus ();

  d5m_capture_ctrl #(.PXL_W(32), .FCNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .in_valid      (in_valid),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .capture_gate  (capture_gate),
    .pattern_enable(pattern_enable),
    .buffer_base   (buffer_base),
    .buffer_swap   (buffer_swap),
    .irq           (irq)
  );

  always @(negedge clk) if (buffer_swap) swap_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    bus.slave_chipselect = 1'b1;
    bus.slave_write      = 1'b1;
    bus.slave_address    = a;
    bus.slave_writedata  = d;
    tick();
    bus.slave_chipselect = 1'b0;
    bus.slave_write      = 1'b0;
  endtask

  task automatic csr_rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.slave_chipselect = 1'b1;
    bus.slave_read       = 1'b1;
    bus.slave_address    = a;
    tick();
    bus.slave_chipselect = 1'b0;
    bus.slave_read       = 1'b0;
    chk_eq(tag, bus.slave_readdata, exp);
  endtask

  function automatic logic [31:0] exp_base();
    return m_idx ? buf1 : buf0;
  endfunction

  task automatic set_ctrl(input logic [3:0] v);
    logic rising;
    rising = v[0] & ~m_run;
    csr_wr(ADDR_CTRL, 32'(v));
    if (rising) begin
      m_count = 0;
      m_idx   = 1'b0;
    end
    m_run  = v[0];
    m_mode = v[1];
    chk_eq("pattern_enable", 32'(pattern_enable), 32'(v[2]));
    tick();
    if (rising) chk_eq("arm_base", buffer_base, buf0);
  endtask

  task automatic drive_beat(input logic sop, input logic eop, input logic exp_gate,
                            input int max_gap, input string tag);
    int gap;
    gap = $urandom_range(0, max_gap);
    repeat (gap) tick();
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    #1;
    chk_eq(tag, 32'(capture_gate), 32'(exp_gate));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Frame completion as the model sees it: count, size, buffer toggle, limit.
  task automatic model_complete(input int len);
    int lim;
    m_count = (m_count + 1) % 65536;
    m_last  = len;
    m_idx   = ~m_idx;
    lim     = (m_limit == 0) ? 1 : m_limit;
    if (m_mode && m_count >= lim) m_run = 1'b0;
  endtask

  task automatic send_frame(input int len, input string tag);
    logic acc;
    acc = m_run;
    for (int i = 0; i < len; i++) drive_beat(i == 0, i == len - 1, acc, 2, tag);
    chk_eq({tag, "_swap"}, 32'(buffer_swap), 32'(acc));
    if (acc) begin
      model_complete(len);
      chk_eq({tag, "_base"}, buffer_base, exp_base());
    end
  endtask

  initial begin
    int len;
    bus.slave_chipselect = 1'b0;
    bus.slave_write      = 1'b0;
    bus.slave_read       = 1'b0;
    bus.slave_address    = '0;
    bus.slave_writedata  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sop   = 1'b1;
    #1;
    chk_eq("rst_gate", 32'(capture_gate), 0);
    chk_eq("rst_readdata", bus.slave_readdata, 0);
    chk_eq("rst_base", buffer_base, 0);
    chk_eq("rst_swap", 32'(buffer_swap), 0);
    chk_eq("rst_irq", 32'(irq), 0);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    rst      = 1'b0;
    tick();
    csr_rd_chk("rst_status", ADDR_STATUS, 0);
    csr_rd_chk("rst_ctrl", ADDR_CTRL, 0);

    // Continuous capture of 4x3 frames, then random-length frames
    buf0 = $urandom;
    buf1 = $urandom;
    csr_wr(ADDR_BUF0_BASE, buf0);
    csr_wr(ADDR_BUF1_BASE, buf1);
    csr_rd_chk("buf1_readback", ADDR_BUF1_BASE, buf1);
    swap_seen = 0;
    set_ctrl(4'h1);
    for (int f = 0; f < 3; f++) send_frame(12, "cont");
    tick();
    chk_eq("cont_swaps", 32'(swap_seen), 3);
    csr_rd_chk("cont_count", ADDR_FRAME_COUNT, 3);
    csr_rd_chk("cont_last", ADDR_LAST_PIXELS, 12);
    for (int f = 0; f < 5; f++) send_frame($urandom_range(2, 40), "rand");
    csr_rd_chk("rand_count", ADDR_FRAME_COUNT, 32'(m_count));
    csr_rd_chk("rand_last", ADDR_LAST_PIXELS, 32'(m_last));

    // Limited capture, LIMIT=2 then LIMIT=0
    set_ctrl(4'h4);
    csr_wr(ADDR_FRAME_LIMIT, 2);
    m_limit = 2;
    set_ctrl(4'h3);
    for (int f = 0; f < 4; f++) send_frame($urandom_range(2, 20), "lim2");
    tick();
    csr_rd_chk("lim2_ctrl", ADDR_CTRL, 32'h2);
    csr_rd_chk("lim2_status", ADDR_STATUS, 32'h2);
    csr_rd_chk("lim2_count", ADDR_FRAME_COUNT, 2);
    csr_wr(ADDR_FRAME_LIMIT, 0);
    m_limit = 0;
    set_ctrl(4'h3);
    for (int f = 0; f < 2; f++) send_frame($urandom_range(2, 20), "lim0");
    csr_rd_chk("lim0_count", ADDR_FRAME_COUNT, 1);

    // Overrun: second sop restarts the pixel count
    csr_wr(ADDR_STATUS, 32'h6);
    set_ctrl(4'h1);
    drive_beat(1'b1, 1'b0, 1'b1, 2, "ovr_gate");
    for (int i = 0; i < 4; i++) drive_beat(1'b0, 1'b0, 1'b1, 2, "ovr_gate");
    drive_beat(1'b1, 1'b0, 1'b1, 2, "ovr_gate");
    for (int i = 0; i < 10; i++) drive_beat(1'b0, 1'b0, 1'b1, 2, "ovr_gate");
    drive_beat(1'b0, 1'b1, 1'b1, 2, "ovr_gate");
    model_complete(12);
    csr_rd_chk("ovr_status", ADDR_STATUS, 32'hF);
    csr_rd_chk("ovr_count", ADDR_FRAME_COUNT, 32'(m_count));
    csr_rd_chk("ovr_last", ADDR_LAST_PIXELS, 12);
    csr_wr(ADDR_STATUS, 32'h4);
    csr_rd_chk("ovr_w1c", ADDR_STATUS, 32'hB);

    // Graceful stop: run cleared on the 7th of 12 beats
    set_ctrl(4'h0);
    set_ctrl(4'h1);
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        bus.slave_chipselect = 1'b1;
        bus.slave_write      = 1'b1;
        bus.slave_address    = ADDR_CTRL;
        bus.slave_writedata  = 32'h0;
      end
      drive_beat(i == 0, i == 11, 1'b1, 0, "stop_gate");
      bus.slave_chipselect = 1'b0;
      bus.slave_write      = 1'b0;
    end
    m_run = 1'b0;
    model_complete(12);
    chk_eq("stop_swap", 32'(buffer_swap), 1);
    tick();
    csr_rd_chk("stop_status", ADDR_STATUS, 32'hA);
    csr_rd_chk("stop_count", ADDR_FRAME_COUNT, 1);
    send_frame(8, "stop_idle");

    // W1C of frame_done racing the hardware set on the eop beat
    csr_wr(ADDR_STATUS, 32'h6);
    set_ctrl(4'h9);
    len = $urandom_range(3, 20);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) begin
        bus.slave_chipselect = 1'b1;
        bus.slave_write      = 1'b1;
        bus.slave_address    = ADDR_STATUS;
        bus.slave_writedata  = 32'h2;
      end
      drive_beat(i == 0, i == len - 1, 1'b1, 0, "race_gate");
      bus.slave_chipselect = 1'b0;
      bus.slave_write      = 1'b0;
    end
    model_complete(len);
    tick();
    chk_eq("race_irq", 32'(irq), 1);
    csr_rd_chk("race_status", ADDR_STATUS, 32'hB);
    csr_wr(ADDR_STATUS, 32'h2);
    tick();
    chk_eq("irq_cleared", 32'(irq), 0);
    csr_rd_chk("clr_status", ADDR_STATUS, 32'h9);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 5; i++) drive_beat(i == 0, 1'b0, 1'b1, 0, "prerst_gate");
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_gate", 32'(capture_gate), 0);
    chk_eq("arst_base", buffer_base, 0);
    chk_eq("arst_swap", 32'(buffer_swap), 0);
    chk_eq("arst_irq", 32'(irq), 0);
    chk_eq("arst_pattern", 32'(pattern_enable), 0);
    chk_eq("arst_readdata", bus.slave_readdata, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_run = 1'b0; m_mode = 1'b0; m_idx = 1'b0;
    m_count = 0; m_last = 0; m_limit = 0;
    buf0 = '0; buf1 = '0;
    tick();
    drive_beat(1'b0, 1'b1, 1'b0, 0, "post_rst_gate");
    chk_eq("post_rst_swap", 32'(buffer_swap), 0);
    csr_rd_chk("post_rst_count", ADDR_FRAME_COUNT, 0);
    csr_rd_chk("post_rst_status", ADDR_STATUS, 0);
    csr_rd_chk("post_rst_last", ADDR_LAST_PIXELS, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
